dsm_serial_loader: RTL and testbench

//  Configuration sequencer for the fractional-N divider chain. Accepts a parallel

---
 rtl/dsm_serial_loader.sv | 157 +++++++++++++++
 tb/tb_dsm_serial_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_serial_loader.sv
// dsm_serial_loader
// Takes a WORD_W-bit fractional word over a valid/ready handshake and shifts it
// MSB first onto the sclk/sdata/en interface of the DSM serial-to-parallel
// register. One word per frame; a fixed idle gap follows every frame.
module dsm_serial_loader #(
  parameter int WORD_W  = 9,
  parameter int CLK_DIV = 2,
  parameter int GAP     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [WORD_W-1:0] req_word,
  output logic              req_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] cur_word
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              done_d;
  logic              sclk_d, sdata_d, en_d;
  logic [WORD_W-1:0] cur_d;

  // Next-state, counter and shift-buffer logic; pin values are derived from the
  // next state so that sclk/sdata/en/done leave flops with no decode glitches.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    buf_d   = buf_q;
    word_d  = word_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SHIFT_LO;
          buf_d   = req_word;
          word_d  = req_word;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          buf_d = buf_q << 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_SHIFT_LO;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          done_d  = 1'b1;
          div_d   = '0;
          gap_d   = '0;
          state_d = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // sdata follows the buffer MSB only while shifting; it changes only on the
    // LO entry after a HI phase, i.e. when sclk falls.
    sclk_d  = (state_d == S_SHIFT_HI);
    en_d    = (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI) || (state_d == S_HOLD);
    sdata_d = ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) ? buf_d[WORD_W-1] : 1'b0;
    cur_d   = done_d ? word_q : cur_word;
  end

  // State, counters, buffers and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift buffer and word latch are small flops, so they are reset
    // with everything else and a reset leaves no stale frame behind.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      buf_q    <= '0;
      word_q   <= '0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      en       <= 1'b0;
      done     <= 1'b0;
      cur_word <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      buf_q    <= buf_d;
      word_q   <= word_d;
      sclk     <= sclk_d;
      sdata    <= sdata_d;
      en       <= en_d;
      done     <= done_d;
      cur_word <= cur_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;

endmodule

// File: tb/tb_dsm_serial_loader.sv
// tb_dsm_serial_loader
// Two instances (defaults, and CLK_DIV=1/GAP=0) are driven in lock-step by the
// same stimulus. A per-instance reference model, computed from the frame timing
// rules with plain arithmetic, predicts every output on every cycle.
module tb_dsm_serial_loader;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [W-1:0] req_word;

  logic a_ready, a_sclk, a_sdata, a_en, a_busy, a_done;
  logic b_ready, b_sclk, b_sdata, b_en, b_busy, b_done;
  logic [W-1:0] a_cur, b_cur;

  dsm_serial_loader #(.WORD_W(W), .CLK_DIV(2), .GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(a_ready), .sclk(a_sclk), .sdata(a_sdata), .en(a_en),
    .busy(a_busy), .done(a_done), .cur_word(a_cur)
  );

  dsm_serial_loader #(.WORD_W(W), .CLK_DIV(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(b_ready), .sclk(b_sclk), .sdata(b_sdata), .en(b_en),
    .busy(b_busy), .done(b_done), .cur_word(b_cur)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;  // rising edges seen

  typedef struct {
    logic         sclk, sdata, en, done, ready;
    logic [W-1:0] cur;
  } exp_t;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] bits;
    int           done_a, ready_a, done_b, ready_b;
  } vec_t;

  // Model state per instance: edge of last accept (-1 none), that word, and the
  // last fully shifted word before it.
  int           m_acc  [2];
  logic [W-1:0] m_word [2];
  logic [W-1:0] m_cur  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]  = -1;
      m_word[i] = '0;
      m_cur[i]  = '0;
    end
  endtask

  // Expected outputs for instance idx in the cycle following edge ne.
  function automatic exp_t model_out(input int idx, input int ne);
    exp_t o;
    int d, g, f, t, bi;
    d = (idx == 0) ? 2 : 1;
    g = (idx == 0) ? 4 : 0;
    f = 2 * W * d + d;
    o.sclk = 0; o.sdata = 0; o.en = 0; o.done = 0; o.ready = 1;
    o.cur = m_cur[idx];
    if (m_acc[idx] >= 0) begin
      t = ne - m_acc[idx] + 1;
      if (t <= 2 * W * d) begin
        bi      = (t - 1) / (2 * d);
        o.en    = 1;
        o.sclk  = ((t - 1) % (2 * d)) >= d;
        o.sdata = m_word[idx][W-1-bi];
        o.ready = 0;
      end else if (t <= f) begin
        o.en    = 1;
        o.ready = 0;
      end else begin
        o.done  = (t == f + 1);
        o.cur   = m_word[idx];
        o.ready = (t >= f + 1 + g);
      end
    end
    return o;
  endfunction

  function automatic logic [14:0] act_vec(input int idx);
    if (idx == 0) return {a_sclk, a_sdata, a_en, a_done, a_ready, a_busy, a_cur};
    return {b_sclk, b_sdata, b_en, b_done, b_ready, b_busy, b_cur};
  endfunction

  task automatic check_model();
    exp_t o;
    for (int i = 0; i < 2; i++) begin
      o = model_out(i, e);
      check((i == 0) ? "cycle_a" : "cycle_b", 32'(act_vec(i)),
            32'({o.sclk, o.sdata, o.en, o.done, o.ready, ~o.ready, o.cur}));
    end
  endtask

  // One clock: decide accepts from the model, take the edge, update the model,
  // then compare both instances on the falling edge.
  task automatic tick();
    logic         acc [2];
    logic [W-1:0] w;
    exp_t         o;
    w = req_word;
    for (int i = 0; i < 2; i++) begin
      o = model_out(i, e);
      acc[i] = rst_n && req_valid && o.ready;
    end
    @(posedge clk);
    e++;
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (m_acc[i] >= 0) m_cur[i] = m_word[i];
          m_acc[i]  = e;
          m_word[i] = w;
        end
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(a_ready && b_ready) && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(a_ready && b_ready), 32'd1);
  endtask

  // Send one word and measure the frame: bits captured on sclk rises, done and
  // ready cycle numbers relative to the accept edge.
  task automatic run_frame(input vec_t v);
    int   rel, da, ra, db, rb, rises;
    logic prev;
    logic [W-1:0] bits;
    wait_idle();
    req_valid = 1'b1;
    req_word  = v.word;
    tick();
    req_valid = 1'b0;
    req_word  = W'($urandom);
    rel = 1; da = 0; ra = 0; db = 0; rb = 0; rises = 0; bits = '0; prev = 1'b0;
    while (!(ra != 0 && rb != 0) && rel <= 100) begin
      if (a_sclk && !prev) begin
        bits = {bits[W-2:0], a_sdata};
        rises++;
      end
      prev = a_sclk;
      if (a_done  && da == 0) da = rel;
      if (a_ready && ra == 0) ra = rel;
      if (b_done  && db == 0) db = rel;
      if (b_ready && rb == 0) rb = rel;
      if (!(ra != 0 && rb != 0)) begin
        tick();
        rel++;
      end
    end
    check("frame_bits",    32'(bits),  32'(v.bits));
    check("frame_rises",   32'(rises), 32'(W));
    check("frame_done_a",  32'(da),    32'(v.done_a));
    check("frame_ready_a", 32'(ra),    32'(v.ready_a));
    check("frame_done_b",  32'(db),    32'(v.done_b));
    check("frame_ready_b", 32'(rb),    32'(v.ready_b));
    check("frame_cur_a",   32'(a_cur), 32'(v.word));
  endtask

  initial begin
    vec_t vecs [3];
    vec_t tail;
    int   rel, fall, rise, gap_busy, n;
    logic prev_en;

    vecs[0] = '{word: 9'h1A5, bits: 9'b110100101, done_a: 39, ready_a: 43, done_b: 20, ready_b: 20};
    vecs[1] = '{word: 9'h000, bits: 9'b000000000, done_a: 39, ready_a: 43, done_b: 20, ready_b: 20};
    vecs[2] = '{word: 9'h1FF, bits: 9'b111111111, done_a: 39, ready_a: 43, done_b: 20, ready_b: 20};
    tail    = '{word: 9'h0F0, bits: 9'b011110000, done_a: 39, ready_a: 43, done_b: 20, ready_b: 20};

    // Reset values, checked before any clock edge.
    rst_n = 1'b0; req_valid = 1'b0; req_word = '0;
    model_reset();
    #2;
    check("reset_a", 32'(act_vec(0)), 32'({5'b00001, 1'b0, 9'h000}));
    check("reset_b", 32'(act_vec(1)), 32'({5'b00001, 1'b0, 9'h000}));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int i = 0; i < 3; i++) run_frame(vecs[i]);

    // Back-to-back: valid held high; word changes right after the first accept.
    wait_idle();
    req_valid = 1'b1;
    req_word  = 9'h000;
    tick();
    req_word  = 9'h1FF;
    rel = 1; fall = 0; rise = 0; gap_busy = 0; prev_en = a_en;
    while (rise == 0 && rel <= 120) begin
      if (prev_en && !a_en && fall == 0) begin
        fall = rel;
        check("b2b_first_cur", 32'(a_cur), 32'h000);
      end
      if (fall != 0 && !a_en && a_busy) gap_busy++;
      if (fall != 0 && a_en && !prev_en) rise = rel;
      prev_en = a_en;
      if (rise == 0) begin
        tick();
        rel++;
      end
    end
    req_valid = 1'b0;
    check("b2b_fall",     32'(fall),     32'd39);
    check("b2b_rise",     32'(rise),     32'd44);
    check("b2b_gap_busy", 32'(gap_busy), 32'd4);
    n = 0;
    while (!a_done && n < 60) begin
      tick();
      n++;
    end
    check("b2b_second_cur", 32'(a_cur), 32'h1FF);

    // Busy ignore: a one-cycle request in mid-frame must not be queued.
    wait_idle();
    req_valid = 1'b1;
    req_word  = 9'h13C;
    tick();
    req_valid = 1'b0;
    for (rel = 1; rel < 10; rel++) tick();
    req_valid = 1'b1;
    req_word  = 9'h055;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!a_done && n < 60) begin
      tick();
      n++;
    end
    check("ignore_cur", 32'(a_cur), 32'h13C);
    for (int i = 0; i < 8; i++) tick();
    check("ignore_idle", 32'({a_en, a_ready}), 32'b01);

    // Reset in mid-frame: outputs go idle immediately, no done afterwards.
    wait_idle();
    req_valid = 1'b1;
    req_word  = 9'h0B7;
    tick();
    req_valid = 1'b0;
    for (rel = 1; rel < 15; rel++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_a", 32'(act_vec(0)), 32'({5'b00001, 1'b0, 9'h000}));
    check("midreset_b", 32'(act_vec(1)), 32'({5'b00001, 1'b0, 9'h000}));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    run_frame(tail);

    // Randomised traffic with occasional resets, checked cycle by cycle.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(3) == 0);
      req_word  = W'($urandom);
      if ($urandom_range(599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
